// File: rtl/adaptive_binary_if.sv
// Pixel stream bundle for the QR binarizer.
// Master drives pixels and controls; slave returns bits.
interface adaptive_binary_if;
  logic [15:0] pixel_in;
  logic        valid_in;
  logic        line_start_in;
  logic        mode_in;
  logic [7:0]  thresh_in;
  logic [7:0]  offset_in;
  logic        bin_out;
  logic        valid_out;
  logic [7:0]  y_out;

  modport master (
    output pixel_in, valid_in, line_start_in,
    output mode_in, thresh_in, offset_in,
    input  bin_out, valid_out, y_out
  );

  modport slave (
    input  pixel_in, valid_in, line_start_in,
    input  mode_in, thresh_in, offset_in,
    output bin_out, valid_out, y_out
  );
endinterface

// File: rtl/adaptive_binary.sv
// RGB565 -> luma -> 1-bit binarizer, 4-stage pipe.
// Fixed or row-local mean-minus-offset threshold.
module adaptive_binary #(
  parameter int WINDOW = 16,
  parameter bit INVERT = 1'b0
) (
  input logic              clk_in,
  input logic              rst_in,
  adaptive_binary_if.slave bus
);
  localparam int LW = $clog2(WINDOW);
  localparam int SW = 8 + LW;
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] FULL = CW'(WINDOW);

  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [7:0]  r8, g8, b8;
  logic [15:0] pr_d, pg_d, pb_d;

  assign r5 = bus.pixel_in[15:11];
  assign g6 = bus.pixel_in[10:5];
  assign b5 = bus.pixel_in[4:0];
  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};
  assign pr_d = 16'(r8) * 16'd77;
  assign pg_d = 16'(g8) * 16'd150;
  assign pb_d = 16'(b8) * 16'd29;

  logic        s1_v_q, s1_ls_q;
  logic [15:0] s1_r_q, s1_g_q, s1_b_q;
  logic        s2_v_q, s2_ls_q;
  logic [15:0] s2_sum_q;
  logic        s3_v_q, s3_ls_q;
  logic [7:0]  s3_y_q;
  logic        bin_q, vout_q;
  logic [7:0]  y_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  win_q [WINDOW];

  logic       full;
  logic [7:0] mean;
  logic [7:0] adapt_t;
  logic [7:0] thr;
  logic       bin_d;

  // Threshold uses window state before the S3 pixel joins it.
  always_comb begin
    full    = (cnt_q == FULL);
    mean    = 8'(sum_q >> LW);
    adapt_t = (mean > bus.offset_in) ? (mean - bus.offset_in) : 8'd0;
    thr     = bus.thresh_in;
    if (bus.mode_in && full && !s3_ls_q)
      thr = adapt_t;
    bin_d = (s3_y_q >= thr) ^ INVERT;
  end

  // Window bookkeeping; line start restarts the count.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (s3_v_q) begin
      if (s3_ls_q) begin
        sum_d = SW'(s3_y_q);
        cnt_d = CW'(1);
      end else if (full) begin
        sum_d = sum_q + SW'(s3_y_q) - SW'(win_q[WINDOW-1]);
      end else begin
        sum_d = sum_q + SW'(s3_y_q);
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Pipeline stages, output hold and window counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_v_q   <= 1'b0;
      s1_ls_q  <= 1'b0;
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_ls_q  <= 1'b0;
      s2_sum_q <= '0;
      s3_v_q   <= 1'b0;
      s3_ls_q  <= 1'b0;
      s3_y_q   <= '0;
      bin_q    <= 1'b0;
      vout_q   <= 1'b0;
      y_q      <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
    end else begin
      s1_v_q   <= bus.valid_in;
      s1_ls_q  <= bus.valid_in & bus.line_start_in;
      s1_r_q   <= pr_d;
      s1_g_q   <= pg_d;
      s1_b_q   <= pb_d;
      s2_v_q   <= s1_v_q;
      s2_ls_q  <= s1_ls_q;
      s2_sum_q <= s1_r_q + s1_g_q + s1_b_q;
      s3_v_q   <= s2_v_q;
      s3_ls_q  <= s2_ls_q;
      s3_y_q   <= s2_sum_q[15:8];
      vout_q   <= s3_v_q;
      if (s3_v_q) begin
        bin_q <= bin_d;
        y_q   <= s3_y_q;
      end
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // Luma delay line; stale entries are masked by the count.
  always_ff @(posedge clk_in) begin
    if (s3_v_q) begin
      win_q[0] <= s3_y_q;
      for (int i = 1; i < WINDOW; i++)
        win_q[i] <= win_q[i-1];
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.valid_out = vout_q;
  assign bus.y_out     = y_q;
endmodule

// File: tb/tb_adaptive_binary.sv
// Scoreboard bench for adaptive_binary, WINDOW=4.
// A second instance with INVERT=1 shares the stimulus.
module tb_adaptive_binary;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_in;
  int   n_out;
  logic [8:0] expq[$];
  int   hist[$];

  adaptive_binary_if ifa ();
  adaptive_binary_if ifb ();

  assign ifb.pixel_in      = ifa.pixel_in;
  assign ifb.valid_in      = ifa.valid_in;
  assign ifb.line_start_in = ifa.line_start_in;
  assign ifb.mode_in       = ifa.mode_in;
  assign ifb.thresh_in     = ifa.thresh_in;
  assign ifb.offset_in     = ifa.offset_in;

  adaptive_binary #(.WINDOW(W), .INVERT(1'b0)) dut_a (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifa)
  );

  adaptive_binary #(.WINDOW(W), .INVERT(1'b1)) dut_b (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int luma(input logic [15:0] p);
    int r, g, b;
    r = {p[15:11], p[15:13]};
    g = {p[10:5], p[10:9]};
    b = {p[4:0], p[4:2]};
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (ifa.valid_out || ifb.valid_out)) begin
      n_out++;
      checks++;
      if (ifb.valid_out !== ifa.valid_out) begin
        errors++;
        $display("FAIL valid_pair got %b want %b",
                 ifb.valid_out, ifa.valid_out);
      end
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_valid_out got 1 want 0");
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        checks += 3;
        if (ifa.bin_out !== e[8]) begin
          errors++;
          $display("FAIL bin got %b want %b (y %0d)",
                   ifa.bin_out, e[8], e[7:0]);
        end
        if (ifa.y_out !== e[7:0]) begin
          errors++;
          $display("FAIL y_out got %0d want %0d",
                   ifa.y_out, e[7:0]);
        end
        if (ifb.bin_out !== ~e[8]) begin
          errors++;
          $display("FAIL bin_inv got %b want %b",
                   ifb.bin_out, ~e[8]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] px, input logic ls,
                      input logic [8:0] e);
    @(negedge clk);
    ifa.pixel_in      = px;
    ifa.valid_in      = 1'b1;
    ifa.line_start_in = ls;
    expq.push_back(e);
    n_in++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.valid_in      = 1'b0;
      ifa.line_start_in = 1'b0;
      ifa.pixel_in      = 16'($urandom);
    end
  endtask

  task automatic send_m(input logic [15:0] px, input logic ls);
    int y, t, s;
    logic [8:0] e;
    y = luma(px);
    if (ls) hist.delete();
    t = int'(ifa.thresh_in);
    if (ifa.mode_in && !ls && hist.size() >= W) begin
      s = 0;
      foreach (hist[k]) s += hist[k];
      t = s / W - int'(ifa.offset_in);
      if (t < 0) t = 0;
    end
    e = {(y >= t) ? 1'b1 : 1'b0, 8'(y)};
    hist.push_back(y);
    if (hist.size() > W) void'(hist.pop_front());
    send(px, ls, e);
  endtask

  task automatic drain();
    int k;
    idle(1);
    k = 0;
    while (expq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0",
               expq.size());
      expq.delete();
    end
    idle(2);
  endtask

  task automatic set_ctl(input logic m, input logic [7:0] t,
                         input logic [7:0] o);
    @(negedge clk);
    ifa.mode_in   = m;
    ifa.thresh_in = t;
    ifa.offset_in = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (ifa.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", ifa.valid_out);
    end
    if (ifa.bin_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_bin got %b want 0", ifa.bin_out);
    end
    if (ifa.y_out !== 8'd0) begin
      errors++;
      $display("FAIL rst_y got %0d want 0", ifa.y_out);
    end
    if (ifb.bin_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_bin_inv got %b want 0", ifb.bin_out);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_fixed();
    int lat;
    set_ctl(1'b0, 8'd100, 8'd0);
    send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) ifa.valid_in = 1'b0;
    end while (!ifa.valid_out && lat < 10);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency got %0d want 4", lat);
    end
    idle(3);
    send(16'h0000, 1'b0, {1'b0, 8'd0});
    idle(2);
    send(16'hF800, 1'b0, {1'b0, 8'd76});
    send(16'hF81F, 1'b0, {1'b1, 8'd105});
    drain();
  endtask

  task automatic test_adaptive();
    set_ctl(1'b1, 8'd50, 8'd20);
    send(16'hFFFF, 1'b1, {1'b1, 8'd255});
    for (int i = 0; i < 3; i++)
      send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    send(16'hF800, 1'b0, {1'b0, 8'd76});
  endtask

  task automatic test_line_restart();
    send(16'hF800, 1'b1, {1'b1, 8'd76});
    send(16'hF81F, 1'b0, {1'b1, 8'd105});
    drain();
    send(16'hFFFF, 1'b1, {1'b1, 8'd255});
    send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    send(16'hF800, 1'b1, {1'b1, 8'd76});
    send(16'hF800, 1'b0, {1'b1, 8'd76});
    drain();
  endtask

  task automatic test_offset_sat();
    set_ctl(1'b1, 8'd50, 8'd20);
    send(16'h0000, 1'b1, {1'b0, 8'd0});
    for (int i = 0; i < 3; i++)
      send(16'h0000, 1'b0, {1'b0, 8'd0});
    send(16'h0000, 1'b0, {1'b1, 8'd0});
    drain();
  endtask

  task automatic test_gaps();
    int i0, o0;
    set_ctl(1'b1, 8'd50, 8'd20);
    i0 = n_in;
    o0 = n_out;
    for (int rep = 0; rep < 3; rep++) begin
      send(16'hFFFF, 1'b1, {1'b1, 8'd255});
      idle($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
        send(16'hFFFF, 1'b0, {1'b1, 8'd255});
        idle($urandom_range(0, 3));
      end
      send(16'hF800, 1'b0, {1'b0, 8'd76});
      idle($urandom_range(0, 3));
      send(16'hF800, 1'b1, {1'b1, 8'd76});
      idle($urandom_range(0, 3));
    end
    drain();
    checks++;
    if ((n_out - o0) != (n_in - i0)) begin
      errors++;
      $display("FAIL gap_count got %0d want %0d",
               n_out - o0, n_in - i0);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    set_ctl(1'b1, 8'd50, 8'd20);
    send(16'hFFFF, 1'b1, {1'b1, 8'd255});
    for (int i = 0; i < 6; i++)
      send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    @(negedge clk);
    ifa.valid_in = 1'b0;
    #2;
    rst = 1'b1;
    expq.delete();
    hist.delete();
    #1;
    checks += 3;
    if (ifa.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL async_valid got %b want 0", ifa.valid_out);
    end
    if (ifa.y_out !== 8'd0) begin
      errors++;
      $display("FAIL async_y got %0d want 0", ifa.y_out);
    end
    if (ifa.bin_out !== 1'b0) begin
      errors++;
      $display("FAIL async_bin got %b want 0", ifa.bin_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ifa.valid_out) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_after_reset got %0d want 0", seen);
    end
    send(16'hF800, 1'b0, {1'b1, 8'd76});
    for (int i = 0; i < 3; i++)
      send(16'hFFFF, 1'b0, {1'b1, 8'd255});
    send(16'hF800, 1'b0, {1'b0, 8'd76});
    drain();
  endtask

  task automatic test_random();
    int i0, o0;
    i0 = n_in;
    o0 = n_out;
    for (int b = 0; b < 3; b++) begin
      set_ctl(b != 1, 8'($urandom), 8'($urandom_range(0, 60)));
      send_m(16'($urandom), 1'b1);
      for (int i = 0; i < 40; i++) begin
        send_m(16'($urandom), ($urandom_range(0, 9) == 0));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
    end
    checks++;
    if ((n_out - o0) != (n_in - i0)) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d",
               n_out - o0, n_in - i0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_in   = 0;
    n_out  = 0;
    rst    = 1'b1;
    ifa.pixel_in      = '0;
    ifa.valid_in      = 1'b0;
    ifa.line_start_in = 1'b0;
    ifa.mode_in       = 1'b0;
    ifa.thresh_in     = 8'd100;
    ifa.offset_in     = 8'd0;
    test_reset();
    test_fixed();
    test_adaptive();
    test_line_restart();
    test_offset_sat();
    test_gaps();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
